// File: rtl/updown_counter_n.sv
// updown_counter_n
// N-bit loadable up/down counter with a programmable terminal count.
// Each enabled step either wraps or saturates at the bounds, depending on
// the saturate mode. tc is a registered one-cycle pulse for each boundary
// event. busy is high whenever count differs from the reset value.
// With limit set to all ones the block is a plain free-running counter.

module updown_counter_n #(
  parameter int          WIDTH     = 8,
  parameter int unsigned RESET_VAL = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic [WIDTH-1:0] limit,
  input  logic             saturate,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             busy
);

  // Reset value truncated to the counter width.
  localparam logic [WIDTH-1:0] RESET_COUNT = RESET_VAL[WIDTH-1:0];
  localparam logic [WIDTH-1:0] ONE         = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] ZERO        = '0;

  logic [WIDTH-1:0] count_reg;
  logic [WIDTH-1:0] count_next;
  logic             tc_reg;
  logic             tc_next;

  // Boundary conditions of the current count. at_top uses >= so that a value
  // loaded above limit is treated as already being at the upper bound.
  logic             at_top;
  logic             at_zero;
  logic [WIDTH-1:0] count_inc;
  logic [WIDTH-1:0] count_dec;

  assign at_top    = (count_reg >= limit);
  assign at_zero   = (count_reg == ZERO);
  assign count_inc = count_reg + ONE;
  assign count_dec = count_reg - ONE;

  // Next count and tc. The priority is load, then enable, then hold.
  always_comb begin
    count_next = count_reg;
    tc_next    = 1'b0;
    if (load) begin
      count_next = load_val;
    end else if (enable) begin
      if (up) begin
        if (!at_top) begin
          count_next = count_inc;
        end else begin
          // Upper-bound event: wrap to zero, or hold when saturating.
          tc_next = 1'b1;
          if (!saturate) begin
            count_next = ZERO;
          end
        end
      end else begin
        if (!at_zero) begin
          count_next = count_dec;
        end else begin
          // Lower-bound event: wrap to the terminal count, or hold at zero.
          tc_next = 1'b1;
          if (!saturate) begin
            count_next = limit;
          end
        end
      end
    end
  end

  // State register. Reset clears asynchronously and overrides a simultaneous load.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_reg <= RESET_COUNT;
      tc_reg    <= 1'b0;
    end else begin
      count_reg <= count_next;
      tc_reg    <= tc_next;
    end
  end

  // busy: per-bit difference from the reset value, OR-reduced.
  logic [WIDTH-1:0] diff_bits;

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_diff
      assign diff_bits[gi] = count_reg[gi] ^ RESET_COUNT[gi];
    end
  endgenerate

  assign busy  = |diff_bits;
  assign count = count_reg;
  assign tc    = tc_reg;

endmodule

// File: tb/tb_updown_counter_n.sv
// Testbench for updown_counter_n (WIDTH=8, RESET_VAL=0).
// The reference model follows the counter rules with integer arithmetic.
// Directed steps follow the test plan, and a randomized phase follows them.

module tb_updown_counter_n;

  localparam int W   = 8;
  localparam int MAX = (1 << W) - 1;

  logic         clk = 1'b0;
  logic         reset;
  logic         enable;
  logic         up;
  logic         load;
  logic [W-1:0] load_val;
  logic [W-1:0] limit;
  logic         saturate;
  logic [W-1:0] count;
  logic         tc;
  logic         busy;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state.
  int m_count;
  int m_tc;

  always #5 clk = ~clk;

  updown_counter_n #(.WIDTH(W), .RESET_VAL(0)) dut (
    .clk      (clk),
    .reset    (reset),
    .enable   (enable),
    .up       (up),
    .load     (load),
    .load_val (load_val),
    .limit    (limit),
    .saturate (saturate),
    .count    (count),
    .tc       (tc),
    .busy     (busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input string tag);
    check({tag, ".count"}, 32'(count), 32'(m_count));
    check({tag, ".tc"},    32'(tc),    32'(m_tc));
    check({tag, ".busy"},  32'(busy),  32'(m_count != 0));
  endtask

  // Reference behaviour for one rising edge, from the current inputs.
  task automatic model_edge();
    int lim;
    lim = int'(limit);
    if (load) begin
      m_count = int'(load_val);
      m_tc    = 0;
    end else if (!enable) begin
      m_tc = 0;
    end else if (up) begin
      if (m_count < lim) begin
        m_count = m_count + 1;
        m_tc    = 0;
      end else begin
        m_tc = 1;
        if (!saturate) m_count = 0;
      end
    end else begin
      if (m_count > 0) begin
        m_count = m_count - 1;
        m_tc    = 0;
      end else begin
        m_tc = 1;
        if (!saturate) m_count = lim;
      end
    end
  endtask

  // One clock edge: update the model, then sample the DUT 1 ns after the edge.
  task automatic step(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    check_outputs(tag);
    $display("step %-8s load=%0b en=%0b up=%0b sat=%0b lim=%0d -> count=%0d tc=%0b busy=%0b",
             tag, load, enable, up, saturate, limit, count, tc, busy);
  endtask

  // Step, and also compare against a literal value from the test plan.
  task automatic step_exp(input string tag, input int ec, input int et);
    step(tag);
    check({tag, ".plan_count"}, 32'(count), 32'(ec));
    check({tag, ".plan_tc"},    32'(tc),    32'(et));
  endtask

  // Pulse reset between edges. Outputs must clear before any clock edge.
  // This task is called 1 ns after a rising edge.
  task automatic pulse_reset(input string tag);
    #2 reset = 1'b1;
    #1;
    m_count = 0;
    m_tc    = 0;
    check_outputs(tag);
    check({tag, ".async_count"}, 32'(count), 32'd0);
    $display("reset %-8s -> count=%0d tc=%0b busy=%0b", tag, count, tc, busy);
    #1 reset = 1'b0;
  endtask

  initial begin
    reset    = 1'b1;
    enable   = 1'b0;
    up       = 1'b1;
    load     = 1'b0;
    load_val = '0;
    limit    = '0;
    saturate = 1'b0;
    m_count  = 0;
    m_tc     = 0;

    // Reset state while reset is held, before the first clock edge.
    #2;
    check_outputs("reset0");
    #1 reset = 1'b0;

    // Up/wrap with limit=5.
    limit = 8'd5; up = 1'b1; saturate = 1'b0; enable = 1'b1;
    begin
      int exp_c[8] = '{1, 2, 3, 4, 5, 0, 1, 2};
      int exp_t[8] = '{0, 0, 0, 0, 0, 1, 0, 0};
      for (int i = 0; i < 8; i++) step_exp("upwrap", exp_c[i], exp_t[i]);
    end

    // Down/wrap: load 2, then count down with limit=9.
    load = 1'b1; load_val = 8'd2; enable = 1'b0;
    step_exp("ld2", 2, 0);
    load = 1'b0; enable = 1'b1; up = 1'b0; limit = 8'd9;
    begin
      int exp_c[4] = '{1, 0, 9, 8};
      int exp_t[4] = '{0, 0, 1, 0};
      for (int i = 0; i < 4; i++) step_exp("dnwrap", exp_c[i], exp_t[i]);
    end

    // Saturate up from 0 with limit=3.
    load = 1'b1; load_val = 8'd0;
    step_exp("ld0", 0, 0);
    load = 1'b0; limit = 8'd3; saturate = 1'b1; up = 1'b1; enable = 1'b1;
    begin
      int exp_c[6] = '{1, 2, 3, 3, 3, 3};
      int exp_t[6] = '{0, 0, 0, 1, 1, 1};
      for (int i = 0; i < 6; i++) step_exp("satup", exp_c[i], exp_t[i]);
    end
    // Saturate down from 1.
    load = 1'b1; load_val = 8'd1;
    step_exp("ld1", 1, 0);
    load = 1'b0; up = 1'b0;
    step_exp("satdn", 0, 0);
    step_exp("satdn", 0, 1);

    // Load has priority over enable; then hold for three edges.
    saturate = 1'b0; up = 1'b1; limit = 8'hFF;
    load = 1'b1; load_val = 8'hA5; enable = 1'b1;
    step_exp("prio", 8'hA5, 0);
    load = 1'b0; enable = 1'b0;
    for (int i = 0; i < 3; i++) step_exp("hold", 8'hA5, 0);

    // Free-running wrap at 2^W-1.
    load = 1'b1; load_val = 8'hFE;
    step("ldFE");
    load = 1'b0; enable = 1'b1; up = 1'b1;
    step_exp("free", MAX, 0);
    step_exp("free", 0, 1);

    // A value loaded above limit wraps on the next up-step.
    limit = 8'd10; load = 1'b1; load_val = 8'd200;
    step_exp("ldhi", 200, 0);
    load = 1'b0;
    step_exp("hiwrap", 0, 1);

    // Legacy 4-bit sequence 0..15,0.
    limit = 8'd15;
    for (int i = 1; i <= 16; i++) step_exp("legacy", i % 16, (i == 16) ? 1 : 0);

    // Mid-run reset at count=7, then counting resumes from 1.
    limit = 8'hFF; load = 1'b1; load_val = 8'd0;
    step("ld0b");
    load = 1'b0;
    for (int i = 1; i <= 7; i++) step_exp("run", i, 0);
    pulse_reset("midrst");
    step_exp("resume", 1, 0);
    step_exp("resume", 2, 0);

    // Randomized phase.
    for (int i = 0; i < 400; i++) begin
      enable   = ($urandom_range(0, 9) != 0);
      up       = $urandom_range(0, 1);
      load     = ($urandom_range(0, 11) == 0);
      load_val = 8'($urandom);
      saturate = ($urandom_range(0, 3) == 0);
      limit    = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(0, 7)) : 8'($urandom);
      if ($urandom_range(0, 59) == 0) pulse_reset("rndrst");
      step("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Global time limit so the run always terminates.
  initial begin
    #200000;
    n_bad++;
    $display("FAIL timeout: observed no finish, required finish before 200000 ns");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $fatal(1, "timeout");
  end

endmodule
